pixel_sink: RTL and testbench
=============================

PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power of two ≥2: pixel buffer entries.
REQ-002 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port vga_x  input  8  pixel column from drawing engines.
REQ-005 SHALL have port vga_y  input  7  pixel row.
REQ-006 SHALL have port vga_colour  input  3  pixel colour.
REQ-007 SHALL have port vga_write  input  1  pixel strobe, one pixel per high cycle.
REQ-008 SHALL have port clear_start  input  1  request full-screen fill.
REQ-009 SHALL have port clear_colour  input  3  fill colour, sampled with clear_start.
REQ-010 SHALL have port clear_done  output  1  one-cycle pulse at fill end.
REQ-011 SHALL have port busy  output  1  high while state≠IDLE or buffer non-empty.
REQ-012 SHALL have port overflow  output  1  sticky: a pixel was dropped because the buffer was full.
REQ-013 SHALL have port oob  output  1  sticky out-of-bounds drop flag (see Configuration).
REQ-014 SHALL have ports fb_addr output 15, fb_data output 3, fb_write output 1: registered framebuffer write port.

Function
REQ-015 SHALL enqueue {x,y,colour} on every cycle vga_write=1 and count<FIFO_DEPTH, in any state.
REQ-016 SHALL drop the pixel and set overflow when vga_write=1 and count==FIFO_DEPTH, even if a pop occurs that cycle.
REQ-017 SHALL implement states IDLE, CLEAR, DONE; reset enters IDLE.
REQ-018 SHALL, in IDLE with buffer non-empty and clear_start=0, pop one entry per cycle and drive fb_write=1, fb_addr=y*160+x, fb_data=colour on the next cycle (pixel visible on fb port 2 cycles after its vga_write).
REQ-019 SHALL compute fb_addr as (y<<7)+(y<<5)+x in 15 bits, without truncation for in-range pixels.
REQ-020 SHALL, in IDLE with clear_start=1, latch clear_colour, go to CLEAR, and not pop that cycle (clear beats drain).
REQ-021 SHALL, in CLEAR, write fb_addr 0..19199 ascending, one per cycle, fb_data=latched colour; exactly 19200 writes; no pops; incoming pixels still buffered.
REQ-022 SHALL go CLEAR→DONE after address 19199 is issued, assert clear_done for the single DONE cycle, then return to IDLE.
REQ-023 SHALL ignore clear_start outside IDLE.
REQ-024 SHALL deassert fb_write on every cycle with no pop and no clear write.
REQ-025 SHALL preserve buffer order: fb writes appear in vga_write order.

Reset
REQ-026 SHALL on resetn=0, at any time including mid-clear, immediately force state IDLE, empty buffer, clear counter 0, and fb_write, fb_addr, fb_data, clear_done, overflow, oob, busy all 0.

Configuration
REQ-027 SHALL, with PIXEL_SINK_BOUNDS_CHECK_EN defined, drop pixels with x≥160 or y≥120 before enqueue and set oob sticky.
REQ-028 SHALL, without PIXEL_SINK_BOUNDS_CHECK_EN, enqueue all pixels, wrap fb_addr modulo 2^15, and tie oob to 0.

Structure
REQ-029 SHALL place SCREEN_W=160, SCREEN_H=120, FB_PIXELS=19200, FB_ADDR_W=15 and the state encoding in shared package pixel_sink_pkg.
REQ-030 SHALL implement the buffer as sub-module pixel_fifo (push, pop, full, empty, count; parameter DEPTH).

Verification
REQ-031 SHALL cover: single pixel x=10,y=3,colour=5 in IDLE -> fb_write, fb_addr=490, fb_data=5 exactly 2 cycles later, busy low afterwards.
REQ-032 SHALL cover: clear_start with clear_colour=2 -> 19200 consecutive writes addr 0..19199 data 2, clear_done one cycle, then IDLE.
REQ-033 SHALL cover: 12 back-to-back pixels during CLEAR, FIFO_DEPTH=8 -> first 8 written in order after clear_done, last 4 dropped, overflow=1.
REQ-034 SHALL cover: x=159,y=119 -> fb_addr=19199; with PIXEL_SINK_BOUNDS_CHECK_EN, x=160,y=0 -> no write, oob=1.
REQ-035 SHALL cover: resetn low at clear address 5000 -> all outputs 0 asynchronously; after release, new clear restarts at address 0.
REQ-036 SHALL cover: clear_start and vga_write in the same IDLE cycle -> CLEAR entered, pixel buffered, written after clear_done.

Source files
------------

// File: rtl/pixel_sink_pkg.sv
// Shared constants, pixel record and state encoding for the pixel sink.
// Screen geometry is fixed at 160x120, so the framebuffer address fits in 15 bits.
package pixel_sink_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_PIXELS = SCREEN_W * SCREEN_H;
    localparam int FB_ADDR_W = 15;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    localparam logic [FB_ADDR_W-1:0] LAST_CLEAR_ADDR = FB_ADDR_W'(FB_PIXELS - 1);

    // y*160 + x as two shifts and adds; wraps modulo 2^15 for out-of-range input
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                         input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] yw;
        logic [FB_ADDR_W-1:0] xw;
        yw = {{(FB_ADDR_W - Y_W){1'b0}}, y};
        xw = {{(FB_ADDR_W - X_W){1'b0}}, x};
        return (yw << 7) + (yw << 5) + xw;
    endfunction

    function automatic logic pixel_in_bounds(input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Pixel buffer: circular FIFO of pixel records with occupancy count.
// A push into a full buffer is ignored even if a pop happens in the same cycle.
module pixel_fifo
    import pixel_sink_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  pixel_t                   push_data,
    input  logic                     pop,
    output pixel_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    pixel_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_sink.sv
// Buffers pixels from drawing engines and writes them, or a full-screen fill, to the framebuffer.
// Define PIXEL_SINK_BOUNDS_CHECK_EN to drop off-screen pixels and flag them on oob.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
)
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [X_W-1:0]        vga_x,
    input  logic [Y_W-1:0]        vga_y,
    input  logic [COLOUR_W-1:0]   vga_colour,
    input  logic                  vga_write,
    input  logic                  clear_start,
    input  logic [COLOUR_W-1:0]   clear_colour,
    output logic                  clear_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  oob,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [COLOUR_W-1:0]   fb_data,
    output logic                  fb_write
);

    sink_state_t                 state;
    sink_state_t                 state_next;
    logic [FB_ADDR_W-1:0]        clear_cnt;
    logic [COLOUR_W-1:0]         clear_colour_q;
    pixel_t                      in_pixel;
    pixel_t                      head_pixel;
    logic                        pix_ok;
    logic                        accept;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        pop;
    logic                        clear_write;
    logic                        latch_colour;

    assign in_pixel = '{x: vga_x, y: vga_y, colour: vga_colour};

`ifdef PIXEL_SINK_BOUNDS_CHECK_EN
    assign pix_ok = pixel_in_bounds(vga_x, vga_y);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oob <= 1'b0;
        end else if (vga_write && !pix_ok) begin
            oob <= 1'b1;
        end
    end
`else
    assign pix_ok = 1'b1;
    assign oob    = 1'b0;
`endif

    assign accept = vga_write && pix_ok;

    pixel_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (accept),
        .push_data (in_pixel),
        .pop       (pop),
        .pop_data  (head_pixel),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (accept && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A clear request wins over draining in IDLE; the buffer keeps filling during a clear.
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        clear_write  = 1'b0;
        latch_colour = 1'b0;
        clear_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_start) begin
                    latch_colour = 1'b1;
                    state_next   = CLEAR;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            CLEAR: begin
                clear_write = 1'b1;
                if (clear_cnt == LAST_CLEAR_ADDR) state_next = DONE;
            end
            DONE: begin
                clear_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clear_cnt      <= '0;
            clear_colour_q <= '0;
        end else if (latch_colour) begin
            clear_cnt      <= '0;
            clear_colour_q <= clear_colour;
        end else if (clear_write) begin
            clear_cnt      <= clear_cnt + FB_ADDR_W'(1);
        end
    end

    // Address and data hold their last value when no write is issued.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fb_write <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            fb_write <= pop || clear_write;
            if (clear_write) begin
                fb_addr <= clear_cnt;
                fb_data <= clear_colour_q;
            end else if (pop) begin
                fb_addr <= pixel_addr(head_pixel.x, head_pixel.y);
                fb_data <= head_pixel.colour;
            end
        end
    end

    assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: vector table, clear/overflow/reset sequences and a randomized scoreboard run.
// Expected framebuffer writes come from the screen rules (addr = y*160+x) held in a queue.
module tb_pixel_sink;

    localparam int DEPTH = 8;
    localparam int FB    = 19200;

`ifdef PIXEL_SINK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_write;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        clear_done;
    logic        busy;
    logic        overflow;
    logic        oob;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_write;

    always #5 clock = ~clock;

    pixel_sink #(.FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_write    (vga_write),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .busy         (busy),
        .overflow     (overflow),
        .oob          (oob),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_write     (fb_write)
    );

    typedef struct { int addr; int data; } fbw_t;
    typedef struct { int x; int y; int c; int addr; } vec_t;

    int   errors = 0;
    int   checks = 0;
    fbw_t exp_q[$];
    bit   mon_en = 1'b0;
    int   done_pulses = 0;
    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input int c, input bit w,
                                 input bit cs, input int cc);
        vga_x        = 8'(x);
        vga_y        = 7'(y);
        vga_colour   = 3'(c);
        vga_write    = w;
        clear_start  = cs;
        clear_colour = 3'(cc);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int ref_addr(input int x, input int y);
        return (y * 160 + x) % 32768;
    endfunction

    function automatic bit ref_kept(input int x, input int y);
        return !BOUNDS || (x < 160 && y < 120);
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_fb_write"},   int'(fb_write),   0);
        checkOutput({tag, "_fb_addr"},    int'(fb_addr),    0);
        checkOutput({tag, "_fb_data"},    int'(fb_data),    0);
        checkOutput({tag, "_clear_done"}, int'(clear_done), 0);
        checkOutput({tag, "_busy"},       int'(busy),       0);
        checkOutput({tag, "_overflow"},   int'(overflow),   0);
        checkOutput({tag, "_oob"},        int'(oob),        0);
    endtask

    // Scoreboard: every framebuffer write must match the head of the expected queue.
    always @(negedge clock) begin : monitor
        fbw_t e;
        if (mon_en && resetn === 1'b1) begin
            if (clear_done) done_pulses++;
            if (fb_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_fb_write: got addr %0d data %0d, expected no write",
                             fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("fb_seq_addr", int'(fb_addr), e.addr);
                    checkOutput("fb_seq_data", int'(fb_data), e.data);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  bad;
        int  done_bad;
        bit  found;
        bit  exp_oob;
        bit  keep;
        int  rx;
        int  ry;
        int  rc;
        bit  rw;

        vecs[0] = '{10,  3,   5, 490};
        vecs[1] = '{159, 119, 7, 19199};
        vecs[2] = '{0,   0,   1, 0};
        vecs[3] = '{0,   119, 2, 19040};
        vecs[4] = '{159, 0,   3, 159};
        vecs[5] = '{160, 0,   6, 160};
        vecs[6] = '{255, 127, 4, 20575};
        vecs[7] = '{77,  64,  0, 10317};

        resetn = 1'b0;
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clock);
        #1;
        checkAllZero("reset");
        resetn = 1'b1;
        step();

        // Single pixels in IDLE: visible two cycles after the strobe, then idle again.
        exp_oob = 1'b0;
        for (int i = 0; i < 8; i++) begin
            keep = ref_kept(vecs[i].x, vecs[i].y);
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].c, 1'b1, 1'b0, 0);
            step();
            applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
            checkOutput("vec_busy_after_push", int'(busy), int'(keep));
            checkOutput("vec_write_early", int'(fb_write), 0);
            step();
            checkOutput("vec_write", int'(fb_write), int'(keep));
            if (keep) begin
                checkOutput("vec_addr", int'(fb_addr), vecs[i].addr);
                checkOutput("vec_data", int'(fb_data), vecs[i].c);
            end else begin
                exp_oob = 1'b1;
            end
            step();
            checkOutput("vec_write_after", int'(fb_write), 0);
            checkOutput("vec_busy_after", int'(busy), 0);
        end
        checkOutput("vec_oob", int'(oob), int'(exp_oob));
        checkOutput("vec_overflow", int'(overflow), 0);

        // Full clear in colour 2 with 12 pixels arriving during it; only DEPTH fit.
        applyStimulus(0, 0, 0, 1'b0, 1'b1, 2);
        step();
        applyStimulus(20, 10, 0, 1'b1, 1'b0, 0);
        bad = 0;
        done_bad = 0;
        for (int i = 0; i < FB; i++) begin
            step();
            if (!(fb_write === 1'b1 && int'(fb_addr) == i && int'(fb_data) == 2)) bad++;
            if (clear_done !== (i == FB - 1)) done_bad++;
            if (i == 50) checkOutput("clear_busy", int'(busy), 1);
            if (i + 1 < 12) applyStimulus(20 + i + 1, 10 + i + 1, (i + 1) % 8, 1'b1, 1'b0, 0);
            else            applyStimulus(0, 0, 0, 1'b0, (i == 100), 7);
        end
        checkOutput("clear_bad_writes", bad, 0);
        checkOutput("clear_done_bad_cycles", done_bad, 0);
        step();
        checkOutput("post_done_write", int'(fb_write), 0);
        checkOutput("post_done_pulse", int'(clear_done), 0);
        for (int k = 0; k < DEPTH; k++) begin
            step();
            checkOutput("drain_write", int'(fb_write), 1);
            checkOutput("drain_addr", int'(fb_addr), ref_addr(20 + k, 10 + k));
            checkOutput("drain_data", int'(fb_data), k % 8);
        end
        step();
        checkOutput("drain_end_write", int'(fb_write), 0);
        checkOutput("drain_end_busy", int'(busy), 0);
        checkOutput("overflow_sticky", int'(overflow), 1);

        // Clear request and pixel in the same IDLE cycle: pixel waits for the fill.
        exp_q.delete();
        done_pulses = 0;
        for (int a = 0; a < FB; a++) exp_q.push_back('{a, 3});
        exp_q.push_back('{ref_addr(7, 1), 4});
        mon_en = 1'b1;
        applyStimulus(7, 1, 4, 1'b1, 1'b1, 3);
        step();
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
        checkOutput("same_cycle_busy", int'(busy), 1);
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("same_cycle_finished", int'(found), 1);
        step();
        step();
        mon_en = 1'b0;
        checkOutput("same_cycle_remaining", exp_q.size(), 0);
        checkOutput("same_cycle_done_pulses", done_pulses, 1);

        // Asynchronous reset in the middle of a clear, then a fresh clear restarts at 0.
        applyStimulus(0, 0, 0, 1'b0, 1'b1, 6);
        step();
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (fb_write && fb_addr == 15'd5000) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached_addr_5000", int'(found), 1);
        #2 resetn = 1'b0;
        #1;
        checkAllZero("midclear_reset");
        step();
        step();
        resetn = 1'b1;
        step();
        applyStimulus(0, 0, 0, 1'b0, 1'b1, 1);
        step();
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("restart_write", int'(fb_write), 1);
            checkOutput("restart_addr", int'(fb_addr), i);
            checkOutput("restart_data", int'(fb_data), 1);
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // Randomized pixels in IDLE; draining one per cycle keeps the buffer from filling.
        exp_q.delete();
        exp_oob = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rx = int'($urandom_range(0, 255));
            ry = int'($urandom_range(0, 127));
            rc = int'($urandom_range(0, 7));
            rw = ($urandom_range(0, 3) != 0);
            applyStimulus(rx, ry, rc, rw, 1'b0, 0);
            if (rw && ref_kept(rx, ry)) exp_q.push_back('{ref_addr(rx, ry), rc});
            if (rw && !ref_kept(rx, ry)) exp_oob = 1'b1;
            step();
        end
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 0);
        repeat (4) step();
        mon_en = 1'b0;
        checkOutput("random_remaining", exp_q.size(), 0);
        checkOutput("random_oob", int'(oob), int'(exp_oob));
        checkOutput("random_overflow", int'(overflow), 0);
        checkOutput("random_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
